opcode_tag_pool: RTL and testbench
==================================

OPCODE_TAG_POOL -- requirements
Module: opcode_tag_pool

Interface
REQ-001 SHALL have parameter NUM_TYPES, default 5, number of opcode types (READ, WRITE, WAIT, EVICT, TRIM order).
REQ-002 SHALL have parameter TAGS_PER_TYPE, default 64, tags per type; power of two, at least 2.
REQ-003 SHALL derive TYPE_W = clog2(NUM_TYPES) (default 3), IDX_W = clog2(TAGS_PER_TYPE) (default 6), TAG_W = TYPE_W+IDX_W (default 9), CNT_W = clog2(NUM_TYPES*TAGS_PER_TYPE+1).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 alloc_valid  input  1  tag request.
REQ-007 alloc_type  input  TYPE_W  requested opcode type.
REQ-008 alloc_ready  output  1  request accepted this cycle.
REQ-009 alloc_tag  output  TAG_W  granted tag, valid when alloc_valid and alloc_ready and not alloc_err.
REQ-010 alloc_err  output  1  accepted request had illegal type; no tag granted.
REQ-011 free_valid  input  1  tag return; always accepted.
REQ-012 free_tag  input  TAG_W  tag being returned.
REQ-013 flush_valid  input  1  release all tags of one type.
REQ-014 flush_type  input  TYPE_W  type to flush.
REQ-015 in_use_count  output  CNT_W  registered total of allocated tags.
REQ-016 err_double_free  output  1  sticky: free of tag not allocated, or of illegal type.

Function
REQ-017 Tag encoding SHALL be {type, index}: tag = type*TAGS_PER_TYPE + index, so the default base values are 0, 64, 128, 192, 256.
REQ-018 State SHALL be one in-use bit per (type, index) plus in_use_count; no other sequential state except error flag.
REQ-019 alloc_tag SHALL be combinational: lowest free index of alloc_type.
REQ-020 alloc_ready SHALL be 1 when alloc_type >= NUM_TYPES, or when alloc_type has at least one free index and is not the current flush_type under flush_valid; otherwise 0.
REQ-021 alloc_ready SHALL depend only on registered state and current flush inputs; a same-cycle free SHALL NOT make a full type ready (no bypass).
REQ-022 alloc_err SHALL be 1 exactly when alloc_valid and alloc_type >= NUM_TYPES; such requests SHALL be accepted and change no state.
REQ-023 On a legal handshake, the granted bit SHALL be set at the next edge; the tag SHALL not be granted again until freed or flushed.
REQ-024 On free_valid with legal type and set bit, the bit SHALL clear at the next edge.
REQ-025 On flush_valid with flush_type < NUM_TYPES, all bits of that type SHALL clear at the next edge; an illegal flush_type SHALL be ignored.
REQ-026 A free targeting the flushed type in the same cycle SHALL be absorbed by the flush; no error raised, count decremented once per bit.
REQ-027 in_use_count SHALL update each edge by +1 per grant minus the number of bits cleared; simultaneous grant and free SHALL leave it unchanged.
REQ-028 in_use_count SHALL never exceed NUM_TYPES*TAGS_PER_TYPE nor wrap below 0.
REQ-029 Allocation latency: tag visible same cycle as handshake; freed tag reallocatable from the following cycle.

Reset
REQ-030 On rst_n low at a rising edge, all in-use bits, in_use_count and err_double_free SHALL clear; reset SHALL override any same-cycle alloc, free or flush.
REQ-031 During reset cycles, combinational outputs SHALL follow the cleared state after the first reset edge (alloc_tag = type base, alloc_ready = 1 for idle flush).

Configuration
REQ-032 Macro OPCODE_TAG_POOL_FREE_CHECK_EN SHALL control double-free detection.
REQ-033 With it defined, a free of a clear bit or illegal-type tag (outside REQ-026) SHALL set err_double_free at the next edge, held until reset, with no state change.
REQ-034 Without it, such frees SHALL be silently ignored and err_double_free SHALL be tied 0.

Verification
REQ-035 After reset, alloc type 1 four times back-to-back -> tags 64, 65, 66, 67; in_use_count = 4.
REQ-036 Allocate all 64 type-4 tags -> last tag 319, then alloc_ready = 0 for type 4; free 300 and alloc same cycle -> ready stays 0, next cycle grants 300.
REQ-037 alloc_type = 6 -> alloc_ready = 1, alloc_err = 1, in_use_count unchanged.
REQ-038 Hold 10 type-2 tags, flush type 2 with simultaneous free of 130 and alloc type 2 -> alloc stalled, count drops by 10, no error; next alloc type 2 gives 128.
REQ-039 With OPCODE_TAG_POOL_FREE_CHECK_EN, free tag 5 never allocated -> err_double_free = 1 next cycle, sticky until rst_n; without macro -> stays 0.
REQ-040 Assert rst_n low during a grant with 20 tags held -> next cycle in_use_count = 0, type 0 grants tag 0.

Source files
------------

// File: rtl/opcode_tag_pool.sv
// opcode_tag_pool
//   Tag allocator with a separate pool of TAGS_PER_TYPE tags for each of
//   NUM_TYPES opcode types (READ, WRITE, WAIT, EVICT, TRIM).
//   A tag is encoded as {type, index}.
//   Requests are granted combinationally with the lowest free index of the
//   requested type. Tags can be returned one at a time (free) or a whole
//   type at a time (flush).
//
// Ports
//   clk             : clock; all state updates on the rising edge
//   rst_n           : synchronous active-low reset
//   alloc_valid     : tag request
//   alloc_type      : requested opcode type
//   alloc_ready     : request accepted this cycle
//   alloc_tag       : granted tag (meaningful on a legal handshake)
//   alloc_err       : accepted request carried an illegal type; no tag granted
//   free_valid      : tag return; always accepted
//   free_tag        : tag being returned
//   flush_valid     : release every tag of flush_type
//   flush_type      : type to flush
//   in_use_count    : registered total of allocated tags
//   err_double_free : sticky flag for a bad free (build option, see below)
//
// Build option
//   OPCODE_TAG_POOL_FREE_CHECK_EN : when defined, double-free detection is
//   enabled. A free of a clear bit, or of a tag with an illegal type, sets
//   err_double_free until reset. When the macro is not defined, such frees
//   are ignored and err_double_free is tied to 0.

module opcode_tag_pool #(
  parameter  int NUM_TYPES     = 5,
  parameter  int TAGS_PER_TYPE = 64,
  localparam int TYPE_W        = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1,
  localparam int IDX_W         = $clog2(TAGS_PER_TYPE),
  localparam int TAG_W         = TYPE_W + IDX_W,
  localparam int CNT_W         = $clog2(NUM_TYPES * TAGS_PER_TYPE + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [TYPE_W-1:0] alloc_type,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              alloc_err,
  input  logic              free_valid,
  input  logic [TAG_W-1:0]  free_tag,
  input  logic              flush_valid,
  input  logic [TYPE_W-1:0] flush_type,
  output logic [CNT_W-1:0]  in_use_count,
  output logic              err_double_free
);

  localparam logic [TYPE_W:0] LP_NUM_TYPES = (TYPE_W+1)'(NUM_TYPES);
  localparam logic [CNT_W:0]  LP_MAX_CNT   = (CNT_W+1)'(NUM_TYPES * TAGS_PER_TYPE);

  // Lowest clear bit of a row; only used when the row has a clear bit.
  function automatic logic [IDX_W-1:0] f_lowest_free(input logic [TAGS_PER_TYPE-1:0] row);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = TAGS_PER_TYPE - 1; i >= 0; i--) begin
      if (!row[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] f_popcount(input logic [TAGS_PER_TYPE-1:0] row);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < TAGS_PER_TYPE; i++) begin
      n = n + CNT_W'(row[i]);
    end
    return n;
  endfunction

  // Count update clamped to [0, NUM_TYPES*TAGS_PER_TYPE].
  function automatic logic [CNT_W-1:0] f_sat_count(input logic [CNT_W:0]   up,
                                                   input logic [CNT_W-1:0] dn);
    logic [CNT_W:0] diff;
    if ({1'b0, dn} > up) return '0;
    diff = up - {1'b0, dn};
    if (diff > LP_MAX_CNT) return LP_MAX_CNT[CNT_W-1:0];
    return diff[CNT_W-1:0];
  endfunction

  logic [NUM_TYPES-1:0][TAGS_PER_TYPE-1:0] r_inuse;
  logic [CNT_W-1:0]                        r_cnt;

  logic                                    w_alloc_legal;
  logic [TAGS_PER_TYPE-1:0]                w_alloc_row;
  logic [IDX_W-1:0]                        w_alloc_idx;
  logic                                    w_alloc_has_free;
  logic                                    w_grant;
  logic                                    w_flush_legal;
  logic [TAGS_PER_TYPE-1:0]                w_flush_row;
  logic [TYPE_W-1:0]                       w_free_type;
  logic [IDX_W-1:0]                        w_free_idx;
  logic                                    w_free_legal;
  logic [TAGS_PER_TYPE-1:0]                w_free_row;
  logic                                    w_free_set;
  logic                                    w_absorbed;
  logic                                    w_free_clr;
  logic [CNT_W-1:0]                        w_cleared;
  logic [NUM_TYPES-1:0][TAGS_PER_TYPE-1:0] w_inuse_next;
  logic [CNT_W-1:0]                        w_cnt_next;

  // Allocation side: purely from registered state and flush inputs, so a
  // same-cycle free can never make a full type ready.
  assign w_alloc_legal    = {1'b0, alloc_type} < LP_NUM_TYPES;
  assign w_alloc_row      = w_alloc_legal ? r_inuse[alloc_type] : '1;
  assign w_alloc_idx      = f_lowest_free(w_alloc_row);
  assign w_alloc_has_free = ~&w_alloc_row;

  assign alloc_ready = !w_alloc_legal ||
                       (w_alloc_has_free && !(flush_valid && (flush_type == alloc_type)));
  assign alloc_tag   = {alloc_type, w_alloc_idx};
  assign alloc_err   = alloc_valid && !w_alloc_legal;
  assign w_grant     = alloc_valid && alloc_ready && w_alloc_legal;

  // Flush side; an illegal flush_type selects an all-zero row and does nothing.
  assign w_flush_legal = flush_valid && ({1'b0, flush_type} < LP_NUM_TYPES);
  assign w_flush_row   = w_flush_legal ? r_inuse[flush_type] : '0;

  // Free side. A free aimed at the type being flushed is absorbed: the flush
  // clears the bit, so the free neither clears it again nor raises an error.
  assign w_free_type  = free_tag[TAG_W-1:IDX_W];
  assign w_free_idx   = free_tag[IDX_W-1:0];
  assign w_free_legal = {1'b0, w_free_type} < LP_NUM_TYPES;
  assign w_free_row   = w_free_legal ? r_inuse[w_free_type] : '0;
  assign w_free_set   = w_free_row[w_free_idx];
  assign w_absorbed   = free_valid && w_flush_legal && (w_free_type == flush_type);
  assign w_free_clr   = free_valid && w_free_set && !w_absorbed;

  assign w_cleared  = f_popcount(w_flush_row) + CNT_W'(w_free_clr);
  assign w_cnt_next = f_sat_count({1'b0, r_cnt} + (CNT_W+1)'(w_grant), w_cleared);

  // A grant never targets the flushed type (ready is low) and never targets
  // the freed bit (grant picks a clear bit, free clears a set one), so the
  // three updates touch disjoint bits.
  always_comb begin
    w_inuse_next = r_inuse;
    if (w_free_clr)    w_inuse_next[w_free_type][w_free_idx] = 1'b0;
    if (w_flush_legal) w_inuse_next[flush_type]              = '0;
    if (w_grant)       w_inuse_next[alloc_type][w_alloc_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inuse <= '0;
      r_cnt   <= '0;
    end else begin
      r_inuse <= w_inuse_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign in_use_count = r_cnt;

`ifdef OPCODE_TAG_POOL_FREE_CHECK_EN
  logic r_err;
  logic w_dbl_free;

  // w_free_set is 0 for an illegal type, so that case is covered here too.
  assign w_dbl_free = free_valid && !w_absorbed && !w_free_set;

  always_ff @(posedge clk) begin
    if (!rst_n)          r_err <= 1'b0;
    else if (w_dbl_free) r_err <= 1'b1;
  end

  assign err_double_free = r_err;
`else
  assign err_double_free = 1'b0;
`endif

endmodule

// File: tb/tb_opcode_tag_pool.sv
module tb_opcode_tag_pool;

  localparam int NT   = 5;
  localparam int TPT  = 64;
  localparam int TW   = 3;
  localparam int TAGW = 9;
  localparam int CW   = 9;

  logic            clk;
  logic            rst_n;
  logic            alloc_valid;
  logic [TW-1:0]   alloc_type;
  logic            alloc_ready;
  logic [TAGW-1:0] alloc_tag;
  logic            alloc_err;
  logic            free_valid;
  logic [TAGW-1:0] free_tag;
  logic            flush_valid;
  logic [TW-1:0]   flush_type;
  logic [CW-1:0]   in_use_count;
  logic            err_double_free;

  opcode_tag_pool #(.NUM_TYPES(NT), .TAGS_PER_TYPE(TPT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_valid     (alloc_valid),
    .alloc_type      (alloc_type),
    .alloc_ready     (alloc_ready),
    .alloc_tag       (alloc_tag),
    .alloc_err       (alloc_err),
    .free_valid      (free_valid),
    .free_tag        (free_tag),
    .flush_valid     (flush_valid),
    .flush_type      (flush_type),
    .in_use_count    (in_use_count),
    .err_double_free (err_double_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which tags are held, plus the sticky error.
  bit model_used [NT][TPT];
  bit model_err;

  int n_assert;
  int n_fail;
  int last_tag;
  int last_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_lowest(input int t);
    for (int i = 0; i < TPT; i++) if (!model_used[t][i]) return i;
    return -1;
  endfunction

  function automatic int model_count();
    int n;
    n = 0;
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < TPT; i++) n += int'(model_used[t][i]);
    return n;
  endfunction

  function automatic bit model_ready(input int t, input bit flv, input int flt);
    if (t >= NT) return 1'b1;
    if (flv && flt == t) return 1'b0;
    return model_lowest(t) >= 0;
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, update model,
  // check registered outputs.
  task automatic step(input string name, input bit rn, input bit av, input int at,
                      input bit fv, input int ft, input bit flv, input int flt,
                      input bit pre);
    bit rdy, legal_a, absorbed, dbl;
    int gidx, ftype, fidx;
    rst_n       = rn;
    alloc_valid = av;
    alloc_type  = TW'(at);
    free_valid  = fv;
    free_tag    = TAGW'(ft);
    flush_valid = flv;
    flush_type  = TW'(flt);
    #2;
    legal_a = (at < NT);
    rdy     = model_ready(at, flv, flt);
    if (pre) begin
      chk({name, " ready"}, 32'(alloc_ready), 32'(rdy));
      chk({name, " alloc_err"}, 32'(alloc_err), 32'(av && !legal_a));
      if (av && rdy && legal_a)
        chk({name, " tag"}, 32'(alloc_tag), at * TPT + model_lowest(at));
    end
    last_tag   = int'(alloc_tag);
    last_ready = int'(alloc_ready);
    gidx = (av && rdy && legal_a) ? model_lowest(at) : -1;
    @(posedge clk);
    if (!rn) begin
      for (int t = 0; t < NT; t++)
        for (int i = 0; i < TPT; i++) model_used[t][i] = 1'b0;
      model_err = 1'b0;
    end else begin
      ftype    = ft / TPT;
      fidx     = ft % TPT;
      absorbed = fv && flv && (flt < NT) && (ftype == flt);
      dbl      = 1'b0;
      if (fv && !absorbed) begin
        if (ftype < NT && model_used[ftype][fidx]) model_used[ftype][fidx] = 1'b0;
        else dbl = 1'b1;
      end
      if (flv && flt < NT)
        for (int i = 0; i < TPT; i++) model_used[flt][i] = 1'b0;
      if (gidx >= 0) model_used[at][gidx] = 1'b1;
`ifdef OPCODE_TAG_POOL_FREE_CHECK_EN
      if (dbl) model_err = 1'b1;
`endif
    end
    #1;
    chk({name, " count"}, 32'(in_use_count), model_count());
    chk({name, " err_double_free"}, 32'(err_double_free), 32'(model_err));
  endtask

  task automatic idle(input string name);
    step(name, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic do_reset();
    step("reset0", 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    step("reset1", 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic alloc(input string name, input int t);
    step(name, 1'b1, 1'b1, t, 1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    alloc_valid = 1'b0;
    alloc_type  = '0;
    free_valid  = 1'b0;
    free_tag    = '0;
    flush_valid = 1'b0;
    flush_type  = '0;
    model_err   = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    chk("reset count", 32'(in_use_count), 0);
    #0;
    alloc_type = 3'd0;
    #1;
    chk("reset tag base", 32'(alloc_tag), 0);
    chk("reset ready", 32'(alloc_ready), 1);

    // Four back-to-back type-1 allocations.
    for (int k = 0; k < 4; k++) begin
      alloc("type1 alloc", 1);
      chk("type1 tag seq", last_tag, 64 + k);
    end
    chk("type1 count", 32'(in_use_count), 4);

    // Illegal type: accepted with error, no state change.
    alloc("illegal type", 6);
    chk("illegal ready", last_ready, 1);
    chk("illegal count", 32'(in_use_count), 4);

    // Fill type 4.
    for (int k = 0; k < 64; k++) alloc("type4 fill", 4);
    chk("type4 last tag", last_tag, 319);
    alloc("type4 full", 4);
    chk("type4 full ready", last_ready, 0);
    step("free300+alloc4", 1'b1, 1'b1, 4, 1'b1, 300, 1'b0, 0, 1'b1);
    chk("no bypass ready", last_ready, 0);
    alloc("realloc 300", 4);
    chk("realloc 300 tag", last_tag, 300);

    // Flush type 2 with simultaneous free and alloc.
    do_reset();
    for (int k = 0; k < 10; k++) alloc("type2 hold", 2);
    step("flush2+free130+alloc2", 1'b1, 1'b1, 2, 1'b1, 130, 1'b1, 2, 1'b1);
    chk("flush stall ready", last_ready, 0);
    chk("flush count", 32'(in_use_count), 0);
    chk("flush no err", 32'(err_double_free), 0);
    alloc("after flush", 2);
    chk("after flush tag", last_tag, 128);

    // Double free of a never-allocated tag, then stickiness.
    do_reset();
    step("free5", 1'b1, 1'b0, 0, 1'b1, 5, 1'b0, 0, 1'b1);
    idle("sticky1");
    alloc("sticky2", 0);
    idle("sticky3");

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 500; k++) begin
      bit rn, av, fv, flv;
      int at, ft, flt;
      rn  = ($urandom_range(0, 60) != 0);
      av  = ($urandom_range(0, 3) != 0);
      at  = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      fv  = ($urandom_range(0, 2) == 0);
      ft  = $urandom_range(0, 7) * TPT + $urandom_range(0, 15);
      flv = ($urandom_range(0, 24) == 0);
      flt = $urandom_range(0, 7);
      step("random", rn, av, at, fv, ft, flv, flt, 1'b1);
    end

    // Reset during a grant with 20 tags held.
    do_reset();
    for (int k = 0; k < 20; k++) alloc("hold20", 0);
    chk("hold20 count", 32'(in_use_count), 20);
    step("reset during grant", 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    chk("reset override count", 32'(in_use_count), 0);
    alloc("post reset", 0);
    chk("post reset tag", last_tag, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
